// File: rtl/param_bram_loader_pkg.sv
// param_bram_loader_pkg: parameter BRAM memory map, region decode and loader state encoding.
// Shared with the reader side so both decode identical region boundaries.
package param_bram_loader_pkg;

    localparam logic [9:0] WEIGHT_1 = 10'h000;
    localparam logic [9:0] BIAS_1   = 10'h310;
    localparam logic [9:0] WEIGHT_2 = 10'h311;
    localparam logic [9:0] BIAS_2   = 10'h325;
    localparam logic [9:0] WEIGHT_3 = 10'h326;
    localparam logic [9:0] BIAS_3   = 10'h33A;
    localparam logic [9:0] LAST_ADDR = BIAS_3;
    localparam int WORD_COUNT = 827;

    typedef enum logic [2:0] {W1, B1, W2, B2, W3, B3} region_t;

    typedef enum logic [2:0] {
        IDLE, RECV_HI, RECV_LO, WRITE, DONE
`ifdef PARAM_LOAD_CHECKSUM_EN
        , RECV_CK_HI, RECV_CK_LO
`endif
    } load_state_t;

    function automatic region_t region_of(input logic [9:0] addr);
        return addr < BIAS_1  ? W1 :
               addr == BIAS_1 ? B1 :
               addr < BIAS_2  ? W2 :
               addr == BIAS_2 ? B2 :
               addr < BIAS_3  ? W3 : B3;
    endfunction

endpackage

// File: rtl/param_bram_loader.sv
// param_bram_loader: packs a host byte stream into 16-bit words and writes the parameter BRAM 0..LAST_ADDR.
// Define PARAM_LOAD_CHECKSUM_EN to accept a trailing checksum word and report cksum_err.
module param_bram_loader #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 10,
    parameter logic [ADDR_W-1:0] LAST_ADDR = param_bram_loader_pkg::LAST_ADDR
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              start,
    input  logic [7:0]        s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [DATA_W-1:0] bram_wdata,
    output logic              bram_we,
    output logic [2:0]        region,
`ifdef PARAM_LOAD_CHECKSUM_EN
    output logic              cksum_err,
`endif
    output logic              busy,
    output logic              done
);
    import param_bram_loader_pkg::*;

    load_state_t state;
    logic [7:0]  hi;
`ifdef PARAM_LOAD_CHECKSUM_EN
    logic [15:0] sum;
`endif

    assign region = region_of(bram_addr);

    // s_ready and bram_we are registered and track the RECV_* / WRITE states exactly
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state      <= IDLE;
            hi         <= '0;
            s_ready    <= 1'b0;
            bram_addr  <= '0;
            bram_wdata <= '0;
            bram_we    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
`ifdef PARAM_LOAD_CHECKSUM_EN
            sum        <= '0;
            cksum_err  <= 1'b0;
`endif
        end else begin
            bram_we <= 1'b0;
            case (state)
                IDLE, DONE: if (start) begin
                    bram_addr <= '0;
                    busy      <= 1'b1;
                    done      <= 1'b0;
                    s_ready   <= 1'b1;
                    state     <= RECV_HI;
`ifdef PARAM_LOAD_CHECKSUM_EN
                    sum       <= '0;
                    cksum_err <= 1'b0;
`endif
                end
                RECV_HI: if (s_valid && s_ready) begin
                    hi    <= s_data;
                    state <= RECV_LO;
                end
                RECV_LO: if (s_valid && s_ready) begin
                    bram_wdata <= {hi, s_data};
                    bram_we    <= 1'b1;
                    s_ready    <= 1'b0;
                    state      <= WRITE;
`ifdef PARAM_LOAD_CHECKSUM_EN
                    sum        <= sum + {hi, s_data};
`endif
                end
                WRITE: if (bram_addr == LAST_ADDR) begin
`ifdef PARAM_LOAD_CHECKSUM_EN
                    s_ready <= 1'b1;
                    state   <= RECV_CK_HI;
`else
                    busy    <= 1'b0;
                    done    <= 1'b1;
                    state   <= DONE;
`endif
                end else begin
                    bram_addr <= bram_addr + ADDR_W'(1);
                    s_ready   <= 1'b1;
                    state     <= RECV_HI;
                end
`ifdef PARAM_LOAD_CHECKSUM_EN
                RECV_CK_HI: if (s_valid && s_ready) begin
                    hi    <= s_data;
                    state <= RECV_CK_LO;
                end
                RECV_CK_LO: if (s_valid && s_ready) begin
                    cksum_err <= sum != {hi, s_data};
                    s_ready   <= 1'b0;
                    busy      <= 1'b0;
                    done      <= 1'b1;
                    state     <= DONE;
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_param_bram_loader.sv
// tb_param_bram_loader: randomized byte-stream loads checked against a word-list and memory-map reference model.
// Covers PARAM_LOAD_CHECKSUM_EN when the macro is defined for the build.
module tb_param_bram_loader;

    localparam int NWORDS = 827;
    localparam int LAST   = 'h33A;

    logic        Clk = 1'b0;
    logic        Reset_n, start, s_valid, s_ready, bram_we, busy, done;
    logic [7:0]  s_data;
    logic [9:0]  bram_addr;
    logic [15:0] bram_wdata;
    logic [2:0]  region;
`ifdef PARAM_LOAD_CHECKSUM_EN
    logic        cksum_err;
`endif

    int n_tests = 0, n_fail = 0;
    int cyc = 0, t0 = 0, t1 = 0, wr_count = 0;
    bit abort = 0, prev_we = 0;
    logic [15:0] exp_word [0:1023];
    logic [15:0] bram [0:1023];

    param_bram_loader dut (
        .Clk(Clk), .Reset_n(Reset_n), .start(start),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .bram_addr(bram_addr), .bram_wdata(bram_wdata), .bram_we(bram_we),
        .region(region),
`ifdef PARAM_LOAD_CHECKSUM_EN
        .cksum_err(cksum_err),
`endif
        .busy(busy), .done(done)
    );

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic int ref_region(input int a);
        if (a < 'h310) return 0;
        if (a == 'h310) return 1;
        if (a <= 'h324) return 2;
        if (a == 'h325) return 3;
        if (a <= 'h339) return 4;
        return 5;
    endfunction

    // BRAM model: every write must land at the next address with the next sent word
    always @(negedge Clk) begin
        if (Reset_n && bram_we) begin
            check("wr_addr", bram_addr, wr_count);
            check("wr_data", bram_wdata, exp_word[wr_count[9:0]]);
            check("wr_region", region, ref_region(int'(bram_addr)));
            check("wr_no_ready", s_ready, 1'b0);
            check("wr_single", prev_we, 1'b0);
            bram[bram_addr] = bram_wdata;
            wr_count++;
        end
        prev_we = Reset_n && bram_we;
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        int k;
        if (abort) return;
        repeat (gap) @(negedge Clk);
        s_data  = b;
        s_valid = 1'b1;
        k = 0;
        while (!s_ready && k < 50) begin
            @(negedge Clk);
            k++;
        end
        if (k == 50) begin
            check("ready_timeout", s_ready, 1'b1);
            abort = 1;
        end
        @(negedge Clk);
        s_valid = 1'b0;
    endtask

    task automatic send_word(input logic [15:0] w, input int gap_max);
        send_byte(w[15:8], $urandom_range(gap_max, 0));
        send_byte(w[7:0], $urandom_range(gap_max, 0));
    endtask

    task automatic run_load(input bit addr_data, input int gap_max, input int words,
                            input bit mid_start, input logic [15:0] ck_xor);
        logic [15:0] sum;
        int bad;
        sum = '0;
        for (int i = 0; i < NWORDS; i++) begin
            exp_word[i] = addr_data ? 16'(i) : 16'($urandom);
            sum = sum + exp_word[i];
        end
        for (int i = 0; i < 1024; i++) bram[i] = 'x;
        wr_count = 0;
        abort = 0;
        @(negedge Clk);
        start = 1'b1;
        t0 = cyc;
        @(negedge Clk);
        start = 1'b0;
        check("start_busy", busy, 1'b1);
        check("start_done", done, 1'b0);
        check("start_addr", bram_addr, 0);
        check("start_ready", s_ready, 1'b1);
`ifdef PARAM_LOAD_CHECKSUM_EN
        check("start_ckerr", cksum_err, 1'b0);
`endif
        for (int i = 0; i < words; i++) begin
            if (mid_start && i == 100) begin
                start = 1'b1;
                @(negedge Clk);
                start = 1'b0;
            end
            send_word(exp_word[i], gap_max);
        end
        if (words == NWORDS) begin
`ifdef PARAM_LOAD_CHECKSUM_EN
            send_word(sum ^ ck_xor, gap_max);
`endif
            for (int k = 0; k < 20 && !done; k++) @(negedge Clk);
            t1 = cyc;
            check("end_done", done, 1'b1);
            check("end_busy", busy, 1'b0);
            check("end_ready", s_ready, 1'b0);
            check("end_addr", bram_addr, LAST);
            check("end_region", region, 5);
            check("write_count", wr_count, NWORDS);
            bad = 0;
            for (int i = 0; i < NWORDS; i++) if (bram[i] !== exp_word[i]) bad++;
            check("bram_contents", bad, 0);
`ifdef PARAM_LOAD_CHECKSUM_EN
            check("cksum_err", cksum_err, ck_xor != 0);
`endif
        end
    endtask

    initial begin
        Reset_n = 1'b1;
        start   = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        #2 Reset_n = 1'b0;
        repeat (3) @(negedge Clk);
        check("rst_ready", s_ready, 1'b0);
        check("rst_addr", bram_addr, 0);
        check("rst_wdata", bram_wdata, 0);
        check("rst_we", bram_we, 1'b0);
        check("rst_region", region, 0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
`ifdef PARAM_LOAD_CHECKSUM_EN
        check("rst_ckerr", cksum_err, 1'b0);
`endif
        Reset_n = 1'b1;
        repeat (2) @(negedge Clk);
        check("idle_ready", s_ready, 1'b0);

        // random data, random gaps, ignored start at word 100, corrupted checksum
        run_load(1'b0, 5, NWORDS, 1'b1, 16'h0001);

        // word == address, back-to-back stream, correct checksum; a start from DONE restarts
        run_load(1'b1, 0, NWORDS, 1'b0, 16'h0000);
`ifdef PARAM_LOAD_CHECKSUM_EN
        check("load_cycles", t1 - t0, 3 * NWORDS + 3);
`else
        check("load_cycles", t1 - t0, 3 * NWORDS + 1);
`endif

        // partial load up to address 0x200, then asynchronous reset
        run_load(1'b0, 1, 'h200, 1'b0, 16'h0000);
        send_byte(8'hA5, 0);
        check("mid_addr", bram_addr, 'h200);
        check("mid_busy", busy, 1'b1);
        check("mid_writes", wr_count, 'h200);
        Reset_n = 1'b0;
        #1;
        check("mrst_ready", s_ready, 1'b0);
        check("mrst_addr", bram_addr, 0);
        check("mrst_wdata", bram_wdata, 0);
        check("mrst_we", bram_we, 1'b0);
        check("mrst_region", region, 0);
        check("mrst_busy", busy, 1'b0);
        check("mrst_done", done, 1'b0);
        @(negedge Clk);
        @(negedge Clk);
        Reset_n = 1'b1;
        @(negedge Clk);
        check("mrst_done_hold", done, 1'b0);

        // fresh full load after reset starts again at address 0
        run_load(1'b0, 2, NWORDS, 1'b0, 16'h0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
